// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Size encodings, FSM states and the request fault rule.
package lsu_pkg;

    localparam int MEM_AWIDTH = 9;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Illegal size, misaligned, or beyond the 2 KiB window.
    function automatic logic req_faults(
        input logic [1:0]  size,
        input logic [31:0] addr
    );
        return (size == 2'b11)
            || (size == SZ_HALF && addr[0])
            || (size == SZ_WORD && addr[1:0] != 2'b00)
            || (addr[31:11] != 21'd0);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane extraction and merge.
// Purely combinational; driven from the latched request.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    function automatic logic [31:0] lane_extract(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_WORD: return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_w,
        input logic [31:0] nd,
        input logic [1:0]  sz,
        input logic [1:0]  off
    );
        logic [31:0] m;
        m = old_w;
        case (sz)
            SZ_BYTE: m[{off, 3'b000} +: 8] = nd[7:0];
            SZ_HALF: m[{off[1], 4'b0000} +: 16] = nd[15:0];
            SZ_WORD: m = nd;
            default: m = old_w;
        endcase
        return m;
    endfunction

    // Both views are always computed; the FSM picks which to register.
    always_comb begin
        ext    = lane_extract(word, size, offset, is_unsigned);
        merged = lane_merge(word, wdata, size, offset);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store controller between MEM stage and data memory.
// FSM, request latches, merge and result registers.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_read,
    input  logic [31:0]           mem_q
);

    state_t      state;
    logic        lat_write;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [10:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] ext;
    logic [31:0] merged;
    logic        full_word;

    assign full_word = (lat_size == SZ_WORD);

    lsu_align u_align (
        .word        (mem_q),
        .wdata       (lat_wdata),
        .size        (lat_size),
        .offset      (lat_addr[1:0]),
        .is_unsigned (lat_uns),
        .ext         (ext),
        .merged      (merged)
    );

    // Request sequencing: accept, access, optional write-back, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_write <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            merge_q   <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr[10:0];
                        lat_wdata <= req_wdata;
                        rdata_q   <= '0;
                        fault_q   <= req_faults(req_size, req_addr);
                        state     <= req_faults(req_size, req_addr)
                                   ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!lat_write) begin
                        rdata_q <= ext;
                        state   <= ST_RESP;
                    end else if (full_word) begin
                        state <= ST_RESP;
                    end else begin
                        merge_q <= merged;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP: begin
                    rdata_q <= '0;
                    fault_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and latched request only.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_rdata = resp_valid ? rdata_q : 32'd0;
        resp_fault = resp_valid & fault_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_read   = 1'b0;
        if (state == ST_ACCESS) begin
            mem_addr = lat_addr[10:2];
            if (lat_write && full_word) begin
                mem_we    = 1'b1;
                mem_wdata = lat_wdata;
            end else begin
                mem_read = 1'b1;
            end
        end else if (state == ST_WRITE) begin
            mem_addr  = lat_addr[10:2];
            mem_we    = 1'b1;
            mem_wdata = merge_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit.
// Models the 512-word negedge-write data memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_read;
    logic [31:0] mem_q;

    logic [31:0] mem [0:511];
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    int n_vec;
    int n_bad;

    int          r_lat;
    logic [31:0] r_rd;
    logic        r_f;
    int          r_nwe;
    int          r_nrd;
    int          r_nlow;
    int          r_both;
    logic [8:0]  r_wa;
    logic [31:0] r_wd;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_read     (mem_read),
        .mem_q        (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: write on falling edge, combinational read.
    always @(negedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        else if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    assign mem_q = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issue one request and observe six cycles after acceptance.
    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = -1; r_rd = '0; r_f = 1'b0;
        r_nwe = 0; r_nrd = 0; r_nlow = 0; r_both = 0;
        r_wa = '0; r_wd = '0;
        for (int c = 1; c <= 6; c++) begin
            if (!req_ready) r_nlow++;
            if (mem_read) r_nrd++;
            if (mem_we && mem_read) r_both++;
            if (mem_we) begin
                r_nwe++;
                r_wa = mem_addr;
                r_wd = mem_wdata;
            end
            if (resp_valid) begin
                r_lat = c;
                r_rd  = resp_rdata;
                r_f   = resp_fault;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [1:0]  lv_sz [7];
    logic        lv_u  [7];
    logic [31:0] lv_a  [7];
    logic [31:0] lv_e  [7];
    logic [1:0]  fv_sz [4];
    logic [31:0] fv_a  [4];

    int acc;
    int nresp;
    int run;
    int seen;
    logic rb;

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        preload(9'd4, 32'h0);
        preload(9'd5, 32'h0);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", r_lat, 2);
        chk("sw_nwe", r_nwe, 1);
        chk("sw_nrd", r_nrd, 0);
        chk("sw_addr", r_wa, 4);
        chk("sw_wdata", r_wd, 32'hDEADBEEF);
        chk("sw_ready_low", r_nlow, 2);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        chk("sw_rdata", r_rd, 0);
        chk("sw_fault", r_f, 0);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_lat", r_lat, 2);
        chk("lw_rdata", r_rd, 32'hDEADBEEF);
        chk("lw_nrd", r_nrd, 1);
        chk("lw_nwe", r_nwe, 0);

        preload(9'd4, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAB);
        chk("sb_lat", r_lat, 3);
        chk("sb_nrd", r_nrd, 1);
        chk("sb_nwe", r_nwe, 1);
        chk("sb_both", r_both, 0);
        chk("sb_wdata", r_wd, 32'h11AB3344);
        chk("sb_mem", mem[4], 32'h11AB3344);
        chk("sb_ready_low", r_nlow, 3);

        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234CAFE);
        chk("sh_lat", r_lat, 3);
        chk("sh_addr", r_wa, 5);
        chk("sh_mem", mem[5], 32'hCAFE0000);

        preload(9'd4, 32'h80FF7F01);
        lv_sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        lv_u  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        lv_a  = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h11, 32'h12, 32'h12};
        lv_e  = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF,
                  32'h0000007F, 32'hFFFFFFFF, 32'h000080FF};
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, lv_sz[i], lv_u[i], lv_a[i], 32'h0);
            chk($sformatf("ld%0d_rdata", i), r_rd, lv_e[i]);
            chk($sformatf("ld%0d_lat", i), r_lat, 2);
        end

        fv_sz = '{2'b01, 2'b10, 2'b10, 2'b11};
        fv_a  = '{32'h11, 32'h12, 32'h800, 32'h10};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, fv_sz[i], 1'b0, fv_a[i], 32'h5A5A5A5A);
            chk($sformatf("flt%0d_fault", i), r_f, 1);
            chk($sformatf("flt%0d_lat", i), r_lat, 1);
            chk($sformatf("flt%0d_nwe", i), r_nwe, 0);
            chk($sformatf("flt%0d_nrd", i), r_nrd, 0);
            chk($sformatf("flt%0d_rdata", i), r_rd, 0);
            chk($sformatf("flt%0d_mem", i), mem[4], 32'h80FF7F01);
        end

        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = '0;
        req_valid = 1'b1;
        acc = 0; nresp = 0; run = 0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk) rb = req_ready;
            @(posedge clk);
            #1;
            if (rb) acc++;
            if (resp_valid) nresp++;
            if (!req_ready) begin
                run++;
            end else if (run > 0) begin
                chk("hs_run", run, 2);
                run = 0;
            end
        end
        @(negedge clk) req_valid = 1'b0;
        chk("hs_accepts", acc, 4);
        chk("hs_resps", nresp, 4);
        repeat (2) @(posedge clk);
        #1;

        preload(9'd6, 32'h11223344);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h18; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rw_access_read", mem_read, 1);
        @(posedge clk);
        #1 chk("rw_write_we", mem_we, 1);
        #1 rst_n = 1'b0;
        #1 chk("rw_we_drop", mem_we, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        chk("rw_no_resp", seen, 0);
        chk("rw_ready", req_ready, 1);
        chk("rw_mem", mem[6], 32'h11223344);

        do_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        chk("post_rst_lw", r_rd, 32'h11223344);
        chk("post_rst_lat", r_lat, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
